dec_to_bin_seq: RTL and testbench
=================================

// Module: dec_to_bin_seq
// PURPOSE
//  Sequential BCD-to-binary converter; inverse of the binary-to-decimal digit path.
//  Takes DIGITS packed BCD digits, MSD first, and builds the binary value by
//  repeated acc = acc*10 + digit, one digit per clock.
//  Sits between switch/button input logic and stored-number registers on the DE2-115.
//  Lets decimal entry drive binary datapaths.
// PARAMETERS
//  DIGITS  3  number of BCD digits converted, >=1
//  WIDTH   8  binary result width, >=4
// PORTS
//  clk       in   1          system clock, rising edge
//  rst_n     in   1          asynchronous, active-low reset
//  start     in   1          request; sampled when ready=1
//  bcd_in    in   4*DIGITS   packed digits; [3:0]=ones, [4*DIGITS-1 -:4]=MSD
//  ready     out  1          1 in IDLE and DONE; start accepted
//  busy      out  1          1 while in CONV
//  done      out  1          one-cycle pulse, result/flags valid
//  result    out  WIDTH      converted value, held until next accepted start
//  overflow  out  1          value exceeded 2^WIDTH-1, held with result
//  bad_digit out  1          some digit >9, held with result
// BEHAVIOUR
//  Reset is asynchronous and active-low; everything else is synchronous to clk.
//  Reset values: state=IDLE, ready=1, busy=0, done=0, result=0,
//   overflow=0, bad_digit=0, accumulator and digit counter 0.
//  FSM: IDLE -> CONV on start & ready; CONV -> DONE after DIGITS steps;
//   DONE -> IDLE after one cycle, or DONE -> CONV if start is seen in DONE.
//  Accept at edge k:
//   - latch bcd_in into a shift register.
//   - clear the accumulator and the sticky flags.
//   - go to CONV; busy=1 and ready=0 from edge k.
//  CONV step i=1..DIGITS, at edge k+i: acc <= acc*10 + digit(DIGITS-i), MSD first.
//  Edge k+DIGITS also: go to DONE, load result/overflow/bad_digit, done=1.
//   Latency is DIGITS clocks from the accepting edge to done.
//  done stays high exactly one cycle; result and flags hold until the next accept.
//   The outputs do not change at accept; they update only at the done edge.
//  start when ready=0 (CONV) is ignored; bcd_in changes during CONV are ignored.
//  start in the DONE cycle is accepted, giving back-to-back conversions.
//  Arithmetic: acc is WIDTH+4 bits, with a sticky ovf flag.
//   Set ovf when acc*10+digit > 2^WIDTH-1; once set, acc stays at 2^WIDTH-1.
//  bad digit (>9): set the sticky flag; use the digit value as-is in the arithmetic.
//  Output rule: bad_digit=1 forces result=0; else overflow=1 gives result all-ones.
//   Otherwise result=acc[WIDTH-1:0]. Both flags report independently.
//  Reset mid-CONV aborts the conversion: outputs go to reset values, no done pulse.
// TESTING
//  1 DIGITS=3,WIDTH=8: bcd 0x255, start 1 cycle -> done 3 clk later, result=255, flags 0
//  2 bcd 0x256 -> result=8'hFF, overflow=1, bad_digit=0; bcd 0x000 -> result=0, done once
//  3 bcd 0x1A3 -> bad_digit=1, result=0; the next conversion of 0x042 gives result=42, flags clear
//  4 start held high with 0x123 then 0x099 -> 123 done; 2nd accept only in the DONE cycle
//     -> 99 done 3 clk later; bcd_in changed mid-CONV has no effect
//  5 rst_n low at step 2 of 0x199 -> outputs immediately reset, no done; after release 0x007 -> 7
//  6 DIGITS=4,WIDTH=14: 0x9999 -> 9999 no ovf; WIDTH=13: 0x9999 -> 8191, overflow=1

Source files
------------

// File: rtl/dec_to_bin_seq.sv
// dec_to_bin_seq
//   Sequential BCD-to-binary converter. Accepts DIGITS packed BCD digits
//   (MSD first) and builds the binary value one digit per clock using
//   acc = acc*10 + digit. The accumulator saturates at 2^WIDTH-1 and a sticky
//   overflow flag is set; digits above 9 set a sticky bad_digit flag but are
//   still used as-is in the arithmetic.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      conversion request, taken when ready=1
//   bcd_in     packed digits, [3:0]=ones, top nibble=MSD
//   ready      high in IDLE and DONE (a start will be taken)
//   busy       high while converting
//   done       one-cycle pulse when result/flags are loaded
//   result     converted value (0 on bad digit, all-ones on overflow)
//   overflow   value exceeded 2^WIDTH-1
//   bad_digit  some digit was greater than 9
module dec_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result,
    output logic                  overflow,
    output logic                  bad_digit
);

    localparam int AW = WIDTH + 4;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [AW-1:0] MAXV = {4'b0000, {WIDTH{1'b1}}};
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t              state;
    logic [4*DIGITS-1:0] shreg;
    logic [AW-1:0]       acc;
    logic [CW-1:0]       cnt;
    logic                ovf;
    logic                bad;

    // One conversion step. acc never exceeds 2^WIDTH-1, so acc*10+15 still
    // fits in WIDTH+4 bits and the compare against MAXV is exact.
    logic [3:0]    digit;
    logic [AW-1:0] acc_sum;
    logic [AW-1:0] acc_step;
    logic          step_ovf;
    logic          step_bad;

    always_comb begin
        digit    = shreg[4*DIGITS-1 -: 4];
        acc_sum  = (acc << 3) + (acc << 1) + {{(AW-4){1'b0}}, digit};
        step_ovf = ovf | (acc_sum > MAXV);
        acc_step = step_ovf ? MAXV : acc_sum;
        step_bad = bad | (digit > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            shreg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            bad       <= 1'b0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            bad_digit <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    // ready is 1 in both states, so start alone means accept.
                    // Outputs are left alone here; they change only at done.
                    if (start) begin
                        state <= S_CONV;
                        shreg <= bcd_in;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        bad   <= 1'b0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CONV: begin
                    acc   <= acc_step;
                    ovf   <= step_ovf;
                    bad   <= step_bad;
                    shreg <= shreg << 4;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= S_DONE;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        overflow  <= step_ovf;
                        bad_digit <= step_bad;
                        // bad digit wins over overflow for the reported value
                        if (step_bad)
                            result <= '0;
                        else if (step_ovf)
                            result <= '1;
                        else
                            result <= acc_step[WIDTH-1:0];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_to_bin_seq.sv
module tb_dec_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] bcd_in = '0;
    logic        ready, busy, done, overflow, bad_digit;
    logic [7:0]  result;

    // wide instances share stimulus
    logic        start_w = 1'b0;
    logic [15:0] bcd_w = '0;
    logic        rdy14, bsy14, dn14, ovf14, bad14;
    logic [13:0] res14;
    logic        rdy13, bsy13, dn13, ovf13, bad13;
    logic [12:0] res13;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_to_bin_seq #(.DIGITS(3), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
        .ready(ready), .busy(busy), .done(done), .result(result),
        .overflow(overflow), .bad_digit(bad_digit));

    dec_to_bin_seq #(.DIGITS(4), .WIDTH(14)) u14 (
        .clk(clk), .rst_n(rst_n), .start(start_w), .bcd_in(bcd_w),
        .ready(rdy14), .busy(bsy14), .done(dn14), .result(res14),
        .overflow(ovf14), .bad_digit(bad14));

    dec_to_bin_seq #(.DIGITS(4), .WIDTH(13)) u13 (
        .clk(clk), .rst_n(rst_n), .start(start_w), .bcd_in(bcd_w),
        .ready(rdy13), .busy(bsy13), .done(dn13), .result(res13),
        .overflow(ovf13), .bad_digit(bad13));

    // Reference: the full decimal value is a sum of non-negative terms, so the
    // saturating accumulator overflows exactly when the full value exceeds max.
    function automatic void ref_conv(input logic [15:0] bcd, input int nd, input int w,
                                     output longint res, output bit ovf, output bit bad);
        longint full;
        longint mx;
        int     dg;
        full = 0;
        mx   = (longint'(1) << w) - 1;
        bad  = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            dg   = int'(bcd[4*i +: 4]);
            full = full * 10 + dg;
            if (dg > 9) bad = 1;
        end
        ovf = (full > mx);
        res = bad ? 0 : (ovf ? mx : full);
    endfunction

    // Drive one request on the main DUT; returns at the done cycle (or timeout).
    task automatic convert(input logic [11:0] bcd, output int lat);
        bcd_in = bcd;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 10);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ready, busy, done, result, overflow, bad_digit} !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b bsy=%b dn=%b res=%0d ovf=%b bad=%b, want 1 0 0 0 0 0",
                     ready, busy, done, result, overflow, bad_digit);
        end
        checks++;
        if ({rdy14, bsy14, dn14, res14, rdy13, res13} !== {1'b1, 1'b0, 1'b0, 14'd0, 1'b1, 13'd0}) begin
            errors++;
            $display("FAIL reset_wide: got rdy14=%b res14=%0d rdy13=%b res13=%0d", rdy14, res14, rdy13, res13);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat;
        int npulse;
        // 0x255 with accept-edge observation
        bcd_in = 12'h255;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, ready, done, result} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL accept_outputs: got bsy=%b rdy=%b dn=%b res=%0d, want 1 0 0 0", busy, ready, done, result);
        end
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 10);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL latency_255: got %0d want 3", lat); end
        checks++;
        if ({result, overflow, bad_digit, busy} !== {8'd255, 3'b000}) begin
            errors++;
            $display("FAIL conv_255: got res=%0d ovf=%b bad=%b bsy=%b, want 255 0 0 0", result, overflow, bad_digit, busy);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, ready, result} !== {1'b0, 1'b1, 8'd255}) begin
            errors++;
            $display("FAIL done_pulse_hold: got dn=%b rdy=%b res=%0d, want 0 1 255", done, ready, result);
        end
        // 0x256 overflows
        convert(12'h256, lat);
        checks++;
        if ({lat == 3, result, overflow, bad_digit} !== {1'b1, 8'hFF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL conv_256: got lat=%0d res=%0d ovf=%b bad=%b, want 3 255 1 0", lat, result, overflow, bad_digit);
        end
        @(posedge clk); #1;
        // 0x000: single done pulse, flags clear
        convert(12'h000, lat);
        checks++;
        if ({lat == 3, result, overflow, bad_digit} !== {1'b1, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL conv_000: got lat=%0d res=%0d ovf=%b bad=%b, want 3 0 0 0", lat, result, overflow, bad_digit);
        end
        npulse = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) npulse++;
        end
        checks++;
        if (npulse !== 0) begin errors++; $display("FAIL done_once_000: got %0d extra pulses want 0", npulse); end
    endtask

    task automatic test_bad_digit;
        int lat;
        convert(12'h1A3, lat);
        checks++;
        if ({lat == 3, result, overflow, bad_digit} !== {1'b1, 8'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL conv_1A3: got lat=%0d res=%0d ovf=%b bad=%b, want 3 0 0 1", lat, result, overflow, bad_digit);
        end
        @(posedge clk); #1;
        convert(12'h042, lat);
        checks++;
        if ({lat == 3, result, overflow, bad_digit} !== {1'b1, 8'd42, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL conv_042: got lat=%0d res=%0d ovf=%b bad=%b, want 3 42 0 0", lat, result, overflow, bad_digit);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic exp_done;
        bcd_in = 12'h123;
        start  = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            @(posedge clk); #1;
            exp_done = (c == 3 || c == 7);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL b2b_done_c%0d: got %b want %b", c, done, exp_done);
            end
            if (c == 0 || c == 4) begin
                checks++;
                if ({busy, ready} !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_accept_c%0d: got bsy=%b rdy=%b want 1 0", c, busy, ready);
                end
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (result !== 8'd123) begin errors++; $display("FAIL b2b_res123_c%0d: got %0d want 123", c, result); end
            end
            if (c == 7) begin
                checks++;
                if ({result, overflow, bad_digit} !== {8'd99, 2'b00}) begin
                    errors++;
                    $display("FAIL b2b_res99: got res=%0d ovf=%b bad=%b want 99 0 0", result, overflow, bad_digit);
                end
            end
            if (c == 0) bcd_in = 12'h099;          // mid-CONV change, ignored
            if (c == 4) begin start = 1'b0; bcd_in = 12'h555; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat;
        int npulse;
        bcd_in = 12'h199;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, busy, done, result, overflow, bad_digit} !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got rdy=%b bsy=%b dn=%b res=%0d ovf=%b bad=%b, want 1 0 0 0 0 0",
                     ready, busy, done, result, overflow, bad_digit);
        end
        npulse = 0;
        repeat (2) begin @(posedge clk); #1; if (done) npulse++; end
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; if (done) npulse++; end
        checks++;
        if (npulse !== 0) begin errors++; $display("FAIL reset_mid_nodone: got %0d pulses want 0", npulse); end
        convert(12'h007, lat);
        checks++;
        if ({lat == 3, result, overflow, bad_digit} !== {1'b1, 8'd7, 2'b00}) begin
            errors++;
            $display("FAIL conv_007: got lat=%0d res=%0d ovf=%b bad=%b, want 3 7 0 0", lat, result, overflow, bad_digit);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int          lat;
        logic [11:0] bcd;
        longint      er;
        bit          eo, eb;
        for (int n = 0; n < 40; n++) begin
            for (int d = 0; d < 3; d++) bcd[4*d +: 4] = 4'($urandom_range(0, 11));
            ref_conv({4'h0, bcd}, 3, 8, er, eo, eb);
            convert(bcd, lat);
            checks++;
            if ({lat == 3, result, overflow, bad_digit} !== {1'b1, 8'(er), eo, eb}) begin
                errors++;
                $display("FAIL rand_%03h: got lat=%0d res=%0d ovf=%b bad=%b, want 3 %0d %b %b",
                         bcd, lat, result, overflow, bad_digit, er, eo, eb);
            end
            // gap 0 means the next start lands in the DONE cycle
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wide;
        logic [15:0] vals [8];
        longint      r14, r13;
        bit          o14, b14, o13, b13;
        int          lat;
        vals = '{16'h9999, 16'h8191, 16'h8192, 16'h0000, 16'h1638, 16'h1A00, 16'h0000, 16'h0000};
        for (int n = 6; n < 8; n++) vals[n] = 16'($urandom_range(0, 16'hFFFF));
        for (int n = 0; n < 8; n++) begin
            ref_conv(vals[n], 4, 14, r14, o14, b14);
            ref_conv(vals[n], 4, 13, r13, o13, b13);
            bcd_w   = vals[n];
            start_w = 1'b1;
            @(posedge clk); #1;
            start_w = 1'b0;
            lat = 0;
            do begin @(posedge clk); #1; lat++; end while (!dn14 && lat < 10);
            checks++;
            if ({lat == 4, dn13, res14, ovf14, bad14} !== {1'b1, 1'b1, 14'(r14), o14, b14}) begin
                errors++;
                $display("FAIL wide14_%04h: got lat=%0d dn13=%b res=%0d ovf=%b bad=%b, want 4 1 %0d %b %b",
                         vals[n], lat, dn13, res14, ovf14, bad14, r14, o14, b14);
            end
            checks++;
            if ({res13, ovf13, bad13} !== {13'(r13), o13, b13}) begin
                errors++;
                $display("FAIL wide13_%04h: got res=%0d ovf=%b bad=%b, want %0d %b %b",
                         vals[n], res13, ovf13, bad13, r13, o13, b13);
            end
            @(posedge clk); #1;
        end
        // the two headline cases against fixed values
        bcd_w   = 16'h9999;
        start_w = 1'b1;
        @(posedge clk); #1;
        start_w = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if ({dn14, res14, ovf14, dn13, res13, ovf13} !== {1'b1, 14'd9999, 1'b0, 1'b1, 13'd8191, 1'b1}) begin
            errors++;
            $display("FAIL wide_9999: got res14=%0d ovf14=%b res13=%0d ovf13=%b, want 9999 0 8191 1",
                     res14, ovf14, res13, ovf13);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_bad_digit();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
